ppu_reg_interface: RTL

CPU-facing register file of the PPU: decodes the eight memory-mapped registers ($2000–$2007) and drives PPU state.
- Owns PPUCTRL, PPUMASK, the VBLANK/sprite status flags, the scroll and address latches, OAMADDR and the PPUDATA read buffer.
- Sits directly upstream of the VRAM, palette memory and sprite OAM, and is their only write port from the CPU side.
- Generates NMI to the CPU from the VBLANK pulses issued by the scanline controller.

---
 rtl/ppu_reg_interface.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ppu_reg_interface.sv
// CPU-side register file of the PPU ($2000-$2007): control/mask/scroll/address
// latches, status flags, PPUDATA read buffer, OAM/VRAM/palette write port and NMI.
module ppu_reg_interface #(
  parameter int INC_BIG = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        busy,
  output logic        nmi_n,
  input  logic        vblank_start,
  input  logic        vblank_end,
  input  logic        sprite0_hit,
  input  logic        sprite_ovf,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [4:0]  palette_addr,
  output logic        palette_we,
  output logic [7:0]  palette_wdata,
  input  logic [7:0]  palette_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic [7:0]  ppuctrl,
  output logic [7:0]  ppumask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y
);

  // CPU handshake: a strobe is accepted only when cpu_cs=1 and busy=0; an
  // accepted read answers with a single cpu_rvalid pulse carrying cpu_rdata.
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;
  typedef enum logic [1:0] {F_OAM = 2'd0, F_VRAM = 2'd1, F_PAL = 2'd2} fetch_t;

  state_t      state_q;
  fetch_t      fetch_q;
  logic [13:0] v_q;
  logic        w_q;
  logic [7:0]  buf_q;
  logic        vbl_q, s0_q, ovf_q;
  logic        vbl_d, s0_d, ovf_d;
  logic [7:0]  ppuctrl_q, ppumask_q, scroll_x_q, scroll_y_q;
  logic [7:0]  oam_addr_q, oam_wr_addr_q;
  logic [13:0] wr_addr_q;
  logic [7:0]  wdata_q;
  logic        vram_we_q, palette_we_q, oam_we_q;
  logic [7:0]  rdata_q;
  logic        rvalid_q;
  logic        nmi_n_q;

  logic        acc_wr, acc_rd, v_is_pal;
  logic [13:0] inc;

  assign acc_wr   = cpu_cs && (state_q == IDLE) && !cpu_rw;
  assign acc_rd   = cpu_cs && (state_q == IDLE) && cpu_rw;
  assign v_is_pal = (v_q[13:8] == 6'h3F);
  assign inc      = ppuctrl_q[2] ? 14'(INC_BIG) : 14'd1;

  // A status read wins over a coincident vblank_start; vblank_end wins over all.
  always_comb begin
    vbl_d = vbl_q;
    s0_d  = s0_q;
    ovf_d = ovf_q;
    if (vblank_start) vbl_d = 1'b1;
    if (sprite0_hit)  s0_d  = 1'b1;
    if (sprite_ovf)   ovf_d = 1'b1;
    if (acc_rd && cpu_addr == 3'd2) vbl_d = 1'b0;
    if (vblank_end) begin
      vbl_d = 1'b0;
      s0_d  = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fetch_q       <= F_OAM;
      v_q           <= '0;
      w_q           <= 1'b0;
      buf_q         <= '0;
      vbl_q         <= 1'b0;
      s0_q          <= 1'b0;
      ovf_q         <= 1'b0;
      ppuctrl_q     <= '0;
      ppumask_q     <= '0;
      scroll_x_q    <= '0;
      scroll_y_q    <= '0;
      oam_addr_q    <= '0;
      oam_wr_addr_q <= '0;
      wr_addr_q     <= '0;
      wdata_q       <= '0;
      vram_we_q     <= 1'b0;
      palette_we_q  <= 1'b0;
      oam_we_q      <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      nmi_n_q       <= 1'b1;
    end else begin
      vbl_q        <= vbl_d;
      s0_q         <= s0_d;
      ovf_q        <= ovf_d;
      nmi_n_q      <= ~(ppuctrl_q[7] & vbl_q);
      vram_we_q    <= 1'b0;
      palette_we_q <= 1'b0;
      oam_we_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc_wr) begin
            case (cpu_addr)
              3'd0: ppuctrl_q  <= cpu_wdata;
              3'd1: ppumask_q  <= cpu_wdata;
              3'd3: oam_addr_q <= cpu_wdata;
              3'd4: begin
                oam_we_q      <= 1'b1;
                oam_wr_addr_q <= oam_addr_q;
                wdata_q       <= cpu_wdata;
                oam_addr_q    <= oam_addr_q + 8'd1;
              end
              3'd5: begin
                if (!w_q) scroll_x_q <= cpu_wdata;
                else      scroll_y_q <= cpu_wdata;
                w_q <= ~w_q;
              end
              3'd6: begin
                if (!w_q) v_q[13:8] <= cpu_wdata[5:0];
                else      v_q[7:0]  <= cpu_wdata;
                w_q <= ~w_q;
              end
              3'd7: begin
                // The write address is captured so v can advance immediately.
                wr_addr_q <= v_q;
                wdata_q   <= cpu_wdata;
                if (v_is_pal) palette_we_q <= 1'b1;
                else          vram_we_q    <= 1'b1;
                v_q <= v_q + inc;
              end
              default: ;
            endcase
          end else if (acc_rd) begin
            case (cpu_addr)
              3'd2: begin
                rdata_q  <= {vbl_q, s0_q, ovf_q, 5'b0};
                rvalid_q <= 1'b1;
                w_q      <= 1'b0;
              end
              3'd4: begin
                state_q <= FETCH;
                fetch_q <= F_OAM;
              end
              3'd7: begin
                state_q <= FETCH;
                fetch_q <= v_is_pal ? F_PAL : F_VRAM;
              end
              default: begin
                rdata_q  <= '0;
                rvalid_q <= 1'b1;
              end
            endcase
          end
        end
        FETCH: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b1;
          case (fetch_q)
            F_OAM:  rdata_q <= oam_rdata;
            F_VRAM: begin
              rdata_q <= buf_q;
              buf_q   <= vram_rdata;
              v_q     <= v_q + inc;
            end
            F_PAL: begin
              rdata_q <= palette_rdata;
              buf_q   <= vram_rdata;
              v_q     <= v_q + inc;
            end
            default: ;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // During a write pulse the memories see the captured address, otherwise v.
  assign vram_addr     = {2'b00, vram_we_q ? wr_addr_q : v_q};
  assign palette_addr  = palette_we_q ? wr_addr_q[4:0] : v_q[4:0];
  assign oam_addr      = oam_we_q ? oam_wr_addr_q : oam_addr_q;
  assign vram_we       = vram_we_q;
  assign palette_we    = palette_we_q;
  assign oam_we        = oam_we_q;
  assign vram_wdata    = wdata_q;
  assign palette_wdata = wdata_q;
  assign oam_wdata     = wdata_q;
  assign cpu_rdata     = rdata_q;
  assign cpu_rvalid    = rvalid_q;
  assign busy          = (state_q == FETCH);
  assign nmi_n         = nmi_n_q;
  assign ppuctrl       = ppuctrl_q;
  assign ppumask       = ppumask_q;
  assign scroll_x      = scroll_x_q;
  assign scroll_y      = scroll_y_q;

endmodule
